// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter and auto-refresh scheduler for the SDRAM
// controller. Passes the init sequence through until init completes, then
// grants the SDRAM bus to one source at a time (refresh > write > read) and
// registers the selected command/address/data onto the device pins.
module sdram_arbit #(
  parameter int unsigned REF_PERIOD = 1280
) (
  input  logic        sclk,
  input  logic        srst,
  // init source
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [10:0] init_addr,
  input  logic [1:0]  init_ba,
  // auto-refresh source
  output logic        aref_en,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [10:0] aref_addr,
  output logic        ref_pending,
  output logic        ref_overrun,
  // write source
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic [31:0] wr_data,
  // read source
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [10:0] rd_addr,
  input  logic [1:0]  rd_ba,
  // SDRAM pins
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [10:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic [3:0]  sdram_dqm,
  output logic [31:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARB   = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 32'd1);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] ref_timer_r;
  logic        wrap_s;
  logic        grant_aref_s;
  logic [3:0]  cmd_s;
  logic [10:0] addr_s;
  logic [1:0]  ba_s;
  logic [31:0] dq_out_s;
  logic        dq_oe_s;

  // The timer only runs once init is done; its terminal count is a refresh request.
  assign wrap_s       = (state_r != ST_INIT) && (ref_timer_r == REF_LAST);
  assign grant_aref_s = (state_r == ST_ARB) && (next_state_s == ST_AREF);

  // Next-state selection and the source mux feeding the pin registers.
  always_comb begin
    next_state_s = state_r;
    cmd_s        = CMD_NOP;
    addr_s       = 11'd0;
    ba_s         = 2'd0;
    case (state_r)
      ST_INIT: begin
        cmd_s  = init_cmd;
        addr_s = init_addr;
        ba_s   = init_ba;
        if (init_end) next_state_s = ST_ARB;
        else          next_state_s = ST_INIT;
      end
      ST_ARB: begin
        if (ref_pending)  next_state_s = ST_AREF;
        else if (wr_req)  next_state_s = ST_WRITE;
        else if (rd_req)  next_state_s = ST_READ;
        else              next_state_s = ST_ARB;
      end
      ST_AREF: begin
        cmd_s  = aref_cmd;
        addr_s = aref_addr;
        if (aref_end) next_state_s = ST_ARB;
        else          next_state_s = ST_AREF;
      end
      ST_WRITE: begin
        cmd_s  = wr_cmd;
        addr_s = wr_addr;
        ba_s   = wr_ba;
        if (wr_end) next_state_s = ST_ARB;
        else        next_state_s = ST_WRITE;
      end
      ST_READ: begin
        cmd_s  = rd_cmd;
        addr_s = rd_addr;
        ba_s   = rd_ba;
        if (rd_end) next_state_s = ST_ARB;
        else        next_state_s = ST_READ;
      end
      default: begin
        next_state_s = ST_INIT;
      end
    endcase
  end

  // Write data is driven onto the pad only while the write source owns the bus.
  always_comb begin
    dq_out_s = 32'd0;
    dq_oe_s  = 1'b0;
    if (state_r == ST_WRITE) begin
      dq_out_s = wr_data;
      dq_oe_s  = 1'b1;
    end else begin
      dq_out_s = 32'd0;
      dq_oe_s  = 1'b0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state_r <= ST_INIT;
    else      state_r <= next_state_s;
  end

  // Refresh interval timer: held in INIT, wraps at the end of each period.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst)                   ref_timer_r <= 16'd0;
    else if (state_r == ST_INIT) ref_timer_r <= 16'd0;
    else if (wrap_s)            ref_timer_r <= 16'd0;
    else                        ref_timer_r <= ref_timer_r + 16'd1;
  end

  // Refresh request and sticky overrun; a wrap coinciding with the grant is a fresh request.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (wrap_s)            ref_pending <= 1'b1;
      else if (grant_aref_s) ref_pending <= 1'b0;
      else                   ref_pending <= ref_pending;
      if (wrap_s && ref_pending && !grant_aref_s) ref_overrun <= 1'b1;
      else                                        ref_overrun <= ref_overrun;
    end
  end

  // One-cycle grant pulses marking the first cycle of each granted state.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= grant_aref_s;
      wr_en   <= (state_r == ST_ARB) && (next_state_s == ST_WRITE);
      rd_en   <= (state_r == ST_ARB) && (next_state_s == ST_READ);
    end
  end

  // Registered SDRAM pins, one cycle behind the selected source.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      sdram_cke    <= 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      sdram_addr   <= 11'd0;
      sdram_ba     <= 2'd0;
      sdram_dqm    <= 4'd0;
      sdram_dq_out <= 32'd0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_cke    <= 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_s;
      sdram_addr   <= addr_s;
      sdram_ba     <= ba_s;
      sdram_dqm    <= 4'd0;
      sdram_dq_out <= dq_out_s;
      sdram_dq_oe  <= dq_oe_s;
    end
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed testbench for sdram_arbit with REF_PERIOD=16.
module tb_sdram_arbit;

  localparam logic [3:0]  NOP_CMD   = 4'b0111;
  localparam logic [3:0]  INIT_CMD  = 4'b0010;
  localparam logic [3:0]  AREF_CMD  = 4'b0001;
  localparam logic [3:0]  WR_CMD    = 4'b0100;
  localparam logic [3:0]  RD_CMD    = 4'b0101;
  localparam logic [10:0] INIT_ADDR = 11'h3FF;
  localparam logic [10:0] AREF_ADDR = 11'h400;
  localparam logic [10:0] WR_ADDR   = 11'h155;
  localparam logic [10:0] RD_ADDR   = 11'h2AA;
  localparam logic [31:0] WR_DATA   = 32'hA5A5_1234;

  logic        sclk = 1'b0;
  logic        srst;
  logic        init_end, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [10:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [1:0]  init_ba, wr_ba, rd_ba;
  logic [31:0] wr_data;
  logic        aref_en, wr_en, rd_en, ref_pending, ref_overrun;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [10:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [3:0]  sdram_dqm;
  logic [31:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [3:0]  pin_cmd;
  logic [2:0]  grants;

  int vectors = 0;
  int miscompares = 0;

  assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign grants  = {aref_en, wr_en, rd_en};

  always #5 sclk = ~sclk;

  sdram_arbit #(.REF_PERIOD(16)) dut (
    .sclk(sclk), .srst(srst),
    .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
    .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .ref_pending(ref_pending), .ref_overrun(ref_overrun),
    .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_data(wr_data),
    .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_ba(rd_ba),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_addr(sdram_addr),
    .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe(sdram_dq_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    init_end = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0;
    steps(2);
    srst = 1'b0;
  endtask

  // Safety net: the run is linear, but never let it hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_cmd = 4'd0; init_addr = 11'd0; init_ba = 2'd0;
    aref_cmd = AREF_CMD; aref_addr = AREF_ADDR;
    wr_cmd = WR_CMD; wr_addr = WR_ADDR; wr_ba = 2'd2; wr_data = WR_DATA;
    rd_cmd = RD_CMD; rd_addr = RD_ADDR; rd_ba = 2'd1;
    do_reset();
    srst = 1'b1;

    // ---- reset state (init inputs at 0000 must not reach the pins)
    chk("rst_cke", 32'(sdram_cke), 32'd1);
    chk("rst_cmd", 32'(pin_cmd), 32'(NOP_CMD));
    chk("rst_addr_ba", {19'd0, sdram_addr, sdram_ba}, 32'd0);
    chk("rst_dqm", 32'(sdram_dqm), 32'd0);
    chk("rst_dq", sdram_dq_out, 32'd0);
    chk("rst_oe", 32'(sdram_dq_oe), 32'd0);
    chk("rst_grants", 32'(grants), 32'd0);
    chk("rst_ref", {30'd0, ref_pending, ref_overrun}, 32'd0);

    // ---- INIT pass-through, init_end low for 5 cycles
    srst = 1'b0;
    init_cmd = INIT_CMD; init_addr = INIT_ADDR; init_ba = 2'd3;
    step();
    chk("init_cmd", 32'(pin_cmd), 32'(INIT_CMD));
    chk("init_addr", 32'(sdram_addr), 32'(INIT_ADDR));
    chk("init_ba", 32'(sdram_ba), 32'd3);
    steps(4);
    chk("init_grants", 32'(grants), 32'd0);
    chk("init_timer", 32'(dut.ref_timer_r), 32'd0);
    chk("init_pending", 32'(ref_pending), 32'd0);

    // ---- write beats read; read follows two cycles after wr_end
    init_end = 1'b1;
    step();                                  // E0: INIT -> ARB
    init_end = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    step();                                  // E1: ARB -> WRITE
    chk("wr_en_grant", 32'(grants), 32'b010);
    chk("arb_cmd_nop", 32'(pin_cmd), 32'(NOP_CMD));
    wr_req = 1'b0;
    step();                                  // E2
    chk("wr_en_pulse", 32'(wr_en), 32'd0);
    chk("wr_cmd", 32'(pin_cmd), 32'(WR_CMD));
    chk("wr_addr_ba", {19'd0, sdram_addr, sdram_ba}, {19'd0, WR_ADDR, 2'd2});
    chk("wr_oe", 32'(sdram_dq_oe), 32'd1);
    chk("wr_dq", sdram_dq_out, WR_DATA);
    wr_end = 1'b1;
    step();                                  // E3: WRITE -> ARB
    wr_end = 1'b0;
    chk("rd_en_early", 32'(rd_en), 32'd0);
    step();                                  // E4: ARB -> READ
    chk("rd_en_grant", 32'(grants), 32'b001);
    chk("rd_oe_off", 32'(sdram_dq_oe), 32'd0);
    chk("rd_dq_zero", sdram_dq_out, 32'd0);
    rd_req = 1'b0;
    step();                                  // E5
    chk("rd_cmd", 32'(pin_cmd), 32'(RD_CMD));
    chk("rd_addr_ba", {19'd0, sdram_addr, sdram_ba}, {19'd0, RD_ADDR, 2'd1});
    rd_end = 1'b1;
    step();                                  // E6: READ -> ARB
    rd_end = 1'b0;

    // ---- idle refresh: pending at E16, grant at E17, next pending at E32
    steps(9);                                // E15
    chk("ref1_early", 32'(ref_pending), 32'd0);
    step();                                  // E16
    chk("ref1_pending", 32'(ref_pending), 32'd1);
    chk("ref1_no_grant", 32'(aref_en), 32'd0);
    step();                                  // E17
    chk("ref1_grant", 32'(aref_en), 32'd1);
    chk("ref1_cleared", 32'(ref_pending), 32'd0);
    step();                                  // E18
    chk("aref_pulse", 32'(aref_en), 32'd0);
    chk("aref_cmd", 32'(pin_cmd), 32'(AREF_CMD));
    chk("aref_addr", 32'(sdram_addr), 32'(AREF_ADDR));
    aref_end = 1'b1;
    step();                                  // E19
    aref_end = 1'b0;
    steps(12);                               // E31
    chk("ref2_early", 32'(ref_pending), 32'd0);
    step();                                  // E32
    chk("ref2_pending", 32'(ref_pending), 32'd1);
    step();                                  // E33
    chk("ref2_grant", 32'(aref_en), 32'd1);
    aref_end = 1'b1;
    step();                                  // E34
    aref_end = 1'b0;
    chk("idle_no_overrun", 32'(ref_overrun), 32'd0);

    // ---- long write burst: overrun at second wrap, refresh after burst
    do_reset();
    init_end = 1'b1;
    step();                                  // F0
    init_end = 1'b0; wr_req = 1'b1;
    step();                                  // F1
    chk("ovr_wr_grant", 32'(wr_en), 32'd1);
    wr_req = 1'b0;
    steps(15);                               // F16
    chk("ovr_pending1", {30'd0, ref_pending, ref_overrun}, 32'b10);
    steps(15);                               // F31
    chk("ovr_not_yet", 32'(ref_overrun), 32'd0);
    step();                                  // F32
    chk("ovr_set", {30'd0, ref_pending, ref_overrun}, 32'b11);
    steps(8);                                // F40
    chk("ovr_no_preempt", {31'd0, aref_en}, 32'd0);
    chk("ovr_cmd_still_wr", 32'(pin_cmd), 32'(WR_CMD));
    wr_end = 1'b1;
    step();                                  // F41
    wr_end = 1'b0;
    chk("ovr_aref_early", 32'(aref_en), 32'd0);
    step();                                  // F42
    chk("ovr_aref_grant", 32'(aref_en), 32'd1);
    chk("ovr_pending_clr", 32'(ref_pending), 32'd0);
    aref_end = 1'b1;
    step();                                  // F43
    aref_end = 1'b0;
    chk("ovr_sticky", 32'(ref_overrun), 32'd1);

    // ---- grant coincides with wrap
    do_reset();
    chk("srst_clears_ovr", 32'(ref_overrun), 32'd0);
    init_end = 1'b1;
    step();                                  // G0
    init_end = 1'b0; wr_req = 1'b1;
    step();                                  // G1
    wr_req = 1'b0;
    steps(29);                               // G30
    wr_end = 1'b1;
    step();                                  // G31
    wr_end = 1'b0;
    chk("coin_pre", {29'd0, aref_en, ref_pending, ref_overrun}, 32'b010);
    step();                                  // G32: grant + wrap
    chk("coin_grant", {29'd0, aref_en, ref_pending, ref_overrun}, 32'b110);

    // ---- srst during READ
    do_reset();
    init_end = 1'b1;
    step();                                  // H0
    init_end = 1'b0; rd_req = 1'b1;
    step();                                  // H1
    chk("srst_rd_grant", 32'(rd_en), 32'd1);
    rd_req = 1'b0;
    step();                                  // H2
    chk("srst_rd_cmd", 32'(pin_cmd), 32'(RD_CMD));
    #2;
    srst = 1'b1;
    #1;
    chk("srst_async_cmd", 32'(pin_cmd), 32'(NOP_CMD));
    chk("srst_async_addr", {19'd0, sdram_addr, sdram_ba}, 32'd0);
    chk("srst_async_cke", 32'(sdram_cke), 32'd1);
    @(posedge sclk);
    #1;
    srst = 1'b0; rd_end = 1'b1;
    step();
    chk("srst_init_cmd", 32'(pin_cmd), 32'(INIT_CMD));
    step();
    chk("srst_rd_end_ign", {25'd0, pin_cmd, grants}, {25'd0, INIT_CMD, 3'b000});
    rd_end = 1'b0; init_end = 1'b1;
    step();                                  // I0
    init_end = 1'b0;
    step();                                  // I1
    chk("srst_arb_idle", {25'd0, pin_cmd, grants}, {25'd0, NOP_CMD, 3'b000});
    rd_req = 1'b1;
    step();                                  // I2
    chk("srst_new_grant", 32'(rd_en), 32'd1);
    rd_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
